// File: rtl/upc_scan_receiver_pkg.sv
// upc_scan_pkg: shared FSM states, payload width and classifier item codes.
package upc_scan_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} scan_state_t;
  localparam int PAYLOAD_BITS = 4;
  localparam logic [2:0] SOFA = 3'b000;
  localparam logic [2:0] TRASH = 3'b001;
  localparam logic [2:0] BALL = 3'b011;
  localparam logic [2:0] SWITCH = 3'b100;
  localparam logic [2:0] AIRPODS = 3'b101;
  localparam logic [2:0] CARDS = 3'b110;
endpackage

// File: rtl/upc_scan_receiver_bit_timer.sv
// scan_bit_timer: bit-period counter ticking at half period in START, full period otherwise.
module scan_bit_timer #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic half,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] FULL_END = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] HALF_END = W'(CLKS_PER_BIT / 2 - 1);
  logic [W-1:0] cnt;
  always_comb tick = cnt == (half ? HALF_END : FULL_END);
  always_ff @(posedge clk) cnt <= (reset || clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/upc_scan_receiver.sv
// upc_scan_receiver: serial scanner frame receiver with parity/stop checks and a one-entry output buffer.
module upc_scan_receiver
  import upc_scan_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [2:0] out_upc,
  output logic       out_mark,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  logic [SYNC_STAGES-1:0] sync;
  logic [PAYLOAD_BITS-1:0] shreg;
  logic [1:0] bit_idx;
  logic s_in, s_prev, tick, par, stop_done, good, accept;
  scan_state_t state;
  scan_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk  (clk),
    .reset(reset),
    .clr  (state == IDLE),
    .half (state == START),
    .tick (tick)
  );
  always_comb begin
    s_in = sync[SYNC_STAGES-1];
    busy = state != IDLE;
    stop_done = state == STOP && tick;
    good = ~^{shreg, par} && s_in;
    accept = stop_done && good && (!out_valid || out_ready);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '1;
      s_prev <= 1'b1;
      state <= IDLE;
      bit_idx <= '0;
      shreg <= '0;
      par <= 1'b0;
      out_valid <= 1'b0;
      out_upc <= '0;
      out_mark <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], scan_in};
      s_prev <= s_in;
      frame_err <= stop_done && !good;
      overrun <= stop_done && good && out_valid && !out_ready;
      if (accept) begin
        out_valid <= 1'b1;
        out_upc <= {shreg[0], shreg[1], shreg[2]};
        out_mark <= shreg[3];
      end else if (out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: if (s_prev && !s_in) state <= START;
        START: if (tick) begin
          state <= s_in ? IDLE : DATA;
          bit_idx <= '0;
        end
        DATA: if (tick) begin
          shreg[bit_idx] <= s_in;
          bit_idx <= bit_idx + 2'd1;
          if (bit_idx == 2'd3) state <= PARITY;
        end
        PARITY: if (tick) begin
          par <= s_in;
          state <= STOP;
        end
        STOP: if (tick) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_upc_scan_receiver.sv
// tb_upc_scan_receiver: directed frame tests with immediate-assertion checks.
module tb_upc_scan_receiver;
  import upc_scan_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scan_in = 1'b1;
  logic out_ready = 1'b0;
  logic out_valid, out_mark, frame_err, overrun, busy;
  logic [2:0] out_upc;
  int checks = 0;
  int errors = 0;
  logic seen, seen_busy;

  upc_scan_receiver #(.CLKS_PER_BIT(4), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .scan_in  (scan_in),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_upc  (out_upc),
    .out_mark (out_mark),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives start, U, P, C, M, parity, stop for 4 clocks each; returns on the
  // negedge just before the clock edge on which the DUT samples the stop bit.
  task automatic send_frame(input logic [2:0] upc, input logic m, input logic p, input logic s);
    logic [6:0] bits;
    bits = {s, p, m, upc[0], upc[1], upc[2], 1'b0};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk) scan_in = bits[i];
      repeat (3) @(negedge clk);
    end
    @(negedge clk) scan_in = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      seen = seen | frame_err | overrun | out_valid | busy;
    end
    chk("idle_activity", 8'(seen), 8'h0);
    chk("rst_valid", 8'(out_valid), 8'h0);
    chk("rst_upc", 8'(out_upc), 8'h0);
    chk("rst_mark", 8'(out_mark), 8'h0);
    chk("rst_err", 8'(frame_err), 8'h0);
    chk("rst_ovr", 8'(overrun), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);

    send_frame(BALL, 1'b0, 1'b0, 1'b1);
    chk("ball_valid_early", 8'(out_valid), 8'h0);
    chk("ball_busy_stop", 8'(busy), 8'h1);
    @(negedge clk);
    chk("ball_valid", 8'(out_valid), 8'h1);
    chk("ball_upc", 8'(out_upc), 8'(BALL));
    chk("ball_mark", 8'(out_mark), 8'h0);
    chk("ball_busy", 8'(busy), 8'h0);
    chk("ball_err", 8'(frame_err), 8'h0);
    out_ready = 1'b1;
    @(negedge clk) out_ready = 1'b0;
    chk("ball_drained", 8'(out_valid), 8'h0);
    idle(5);

    send_frame(AIRPODS, 1'b1, 1'b0, 1'b1);
    chk("par_err_early", 8'(frame_err), 8'h0);
    @(negedge clk);
    chk("par_err", 8'(frame_err), 8'h1);
    chk("par_err_valid", 8'(out_valid), 8'h0);
    chk("par_err_ovr", 8'(overrun), 8'h0);
    @(negedge clk);
    chk("par_err_pulse", 8'(frame_err), 8'h0);
    idle(5);

    send_frame(AIRPODS, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("stop_err", 8'(frame_err), 8'h1);
    chk("stop_err_valid", 8'(out_valid), 8'h0);
    @(negedge clk);
    chk("stop_err_pulse", 8'(frame_err), 8'h0);
    idle(5);

    send_frame(SOFA, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("sofa_valid", 8'(out_valid), 8'h1);
    chk("sofa_upc", 8'(out_upc), 8'(SOFA));
    chk("sofa_mark", 8'(out_mark), 8'h1);
    idle(5);
    send_frame(CARDS, 1'b0, 1'b0, 1'b1);
    chk("ovr_early", 8'(overrun), 8'h0);
    @(negedge clk);
    chk("ovr", 8'(overrun), 8'h1);
    chk("ovr_err", 8'(frame_err), 8'h0);
    chk("ovr_valid", 8'(out_valid), 8'h1);
    chk("ovr_upc_kept", 8'(out_upc), 8'(SOFA));
    chk("ovr_mark_kept", 8'(out_mark), 8'h1);
    @(negedge clk);
    chk("ovr_pulse", 8'(overrun), 8'h0);
    out_ready = 1'b1;
    @(negedge clk) out_ready = 1'b0;
    chk("ovr_drained", 8'(out_valid), 8'h0);
    idle(5);

    @(negedge clk) scan_in = 1'b0;
    @(negedge clk) scan_in = 1'b1;
    seen = 1'b0;
    seen_busy = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen = seen | frame_err | out_valid | overrun;
      seen_busy = seen_busy | busy;
    end
    chk("glitch_started", 8'(seen_busy), 8'h1);
    chk("glitch_quiet", 8'(seen), 8'h0);
    chk("glitch_idle", 8'(busy), 8'h0);

    send_frame(SWITCH, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("switch_valid", 8'(out_valid), 8'h1);
    chk("switch_upc", 8'(out_upc), 8'(SWITCH));
    idle(3);
    @(negedge clk) scan_in = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk) scan_in = 1'b1;
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("mid_busy", 8'(busy), 8'h1);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    chk("mid_rst_busy", 8'(busy), 8'h0);
    chk("mid_rst_valid", 8'(out_valid), 8'h0);
    chk("mid_rst_upc", 8'(out_upc), 8'h0);
    chk("mid_rst_mark", 8'(out_mark), 8'h0);
    idle(5);
    send_frame(AIRPODS, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("post_valid", 8'(out_valid), 8'h1);
    chk("post_upc", 8'(out_upc), 8'(AIRPODS));
    chk("post_mark", 8'(out_mark), 8'h1);
    chk("post_err", 8'(frame_err), 8'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/upc_scan_receiver.md
Name: upc_scan_receiver

Overview:
- Upstream stage of the checkout item classifier (UPC → discount/stolen LEDs and HEX item name).
- Receives serial frames from the handheld barcode scanner line and checks start, parity and stop.
- Delivers each valid 3-bit UPC plus secret-mark bit through a one-entry valid/ready buffer.
- Replaces the manual switch inputs SW[9:7]/SW[0] with scanned data.

Parameters:
CLKS_PER_BIT, 5208, clock cycles per serial bit (50 MHz / 9600 baud); minimum 4, sims use 4.
SYNC_STAGES, 2, input synchronizer depth on scan_in; minimum 2.

Ports:
clk  in  1  system clock (CLOCK_50 at top level)
reset  in  1  synchronous, active-high reset
scan_in  in  1  asynchronous serial line from scanner; idles high
out_ready  in  1  downstream consumer accepts item this cycle
out_valid  out  1  buffered item available
out_upc  out  3  {U,P,C}, U = MSB; stable while out_valid
out_mark  out  1  secret mark bit; stable while out_valid
frame_err  out  1  one-cycle pulse: bad parity or bad stop bit
overrun  out  1  one-cycle pulse: good frame dropped because the buffer was full
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: one clock, synchronous, active-high. Clock is clk, reset is reset.
  - All outputs go to 0 and the FSM goes to IDLE.
  - Synchronizer flops are loaded with 1 (line-idle value), so no false start edge occurs after reset.
  - Reset mid-frame aborts the frame silently and empties the buffer.
- Frame, LSB-first in time: start(0), U, P, C, M, parity, stop(1). Parity is even: U^P^C^M^parity = 0.
- The FSM acts on s_in, the SYNC_STAGES-deep synchronized version of scan_in. Bit counter counts 0..CLKS_PER_BIT-1.
- FSM states and transitions:
  - IDLE: when an s_in 1→0 edge is seen, clear the counter and go to START.
  - START: wait CLKS_PER_BIT/2 cycles (integer divide), then sample s_in.
    - If 0: go to DATA with bit_idx = 0.
    - If 1: glitch; go back to IDLE with no error pulse.
  - DATA: every CLKS_PER_BIT cycles, sample s_in into shift register bit bit_idx (0..3 = U,P,C,M).
    - After index 3, go to PARITY.
  - PARITY: after CLKS_PER_BIT cycles, sample the parity bit, then go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample the stop bit and evaluate the frame.
    - Go to IDLE on the next cycle in every case.
- Frame evaluation, on the cycle after the stop sample:
  - Parity error or stop bit = 0: frame_err = 1 for 1 cycle; payload discarded; buffer unchanged.
  - Good frame, buffer empty (or out_valid && out_ready this same cycle): load out_upc/out_mark and set out_valid.
  - Good frame, buffer full and not draining: overrun = 1 for 1 cycle; new payload dropped; old item kept.
  - frame_err and overrun are never asserted together.
- Latency: out_valid rises exactly 1 cycle after the stop-bit sample cycle.
- Output buffer:
  - out_valid stays high until a cycle with out_ready = 1. It clears the next cycle unless a simultaneous load occurs.
  - out_upc/out_mark change only on a load.
  - The buffer holds 0 or 1 entry.
- A new start edge is accepted in IDLE even while out_valid is high, so reception and buffering are independent.
- Line held low in IDLE: only the 1→0 edge starts a frame, so a stuck-low line produces at most one frame attempt.
- Counter width is $clog2(CLKS_PER_BIT). bit_idx is 2 bits.

Decomposition:
- Package upc_scan_pkg:
  - enum scan_state_t {IDLE, START, DATA, PARITY, STOP}
  - localparam PAYLOAD_BITS = 4
  - item-code constants matching the classifier's UPC cases: SOFA = 3'b000, TRASH = 3'b001, BALL = 3'b011, SWITCH = 3'b100, AIRPODS = 3'b101, CARDS = 3'b110
- Sub-module scan_bit_timer:
  - Counter with synchronous clear.
  - Emits a one-cycle tick at half-period (START) and at full-period (other states).
  - Parameterized by CLKS_PER_BIT.
- Synchronizer stays inline.

Test Plan:
- Reset, then 20 idle cycles with scan_in = 1 → all outputs 0, busy = 0, no pulses.
- CLKS_PER_BIT = 4; frame U=0,P=1,C=1,M=0, parity = 0, stop = 1, out_ready = 0 → out_valid = 1 one cycle after the stop sample; out_upc = 3'b011, out_mark = 0. Assert out_ready for 1 cycle → out_valid = 0 the next cycle.
- Frame U=1,P=0,C=1,M=1 with parity = 0 (wrong; correct is 1) → frame_err pulses 1 cycle; out_valid unchanged.
  - Repeat with correct parity but stop = 0 → frame_err pulse.
- out_ready held 0; send 3'b000/M=1 and then 3'b110/M=0, both valid → second frame raises overrun for 1 cycle; buffer still holds out_upc = 000, out_mark = 1.
- 1-cycle low glitch on scan_in in IDLE → START sample reads 1; FSM returns to IDLE with no frame_err and no out_valid.
  - Then assert reset for 1 cycle midway through the DATA state of a valid frame → busy = 0 and out_valid = 0 next cycle; the next full frame is received correctly.
